// File: rtl/adapter_pkg.sv
// adapter_pkg: shared word type, feeder state encoding and size defaults
//   BITWIDTH : base float width; a word carries two exception bits on top
//   BW       : MSB index of a word
//   LEN      : maximum vector length and memory depth
//   AW       : memory address width
package adapter_pkg;
    localparam int BITWIDTH = 12;
    localparam int BW       = BITWIDTH + 1;
    localparam int LEN      = 64;
    localparam int AW       = $clog2(LEN);
    typedef logic [BW:0] fp_word_t;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE, HOLD} feeder_state_t;
endpackage

// File: rtl/neuron_feeder.sv
// neuron_feeder: clears the neuron, streams vec_len weight/data pairs into it, then offers the sum
//   clk, rst (async, active-low)        : clock and reset
//   start, vec_len                      : run request and pair count (clamped to LEN)
//   busy                                : high outside IDLE
//   w_rd_en/w_addr/w_rdata              : weight memory port, 1-cycle read latency
//   d_rd_en/d_addr/d_rdata              : data memory port, 1-cycle read latency
//   n_weight/n_data/n_en/n_clear/n_accum: neuron interface
//   res_data/res_valid/res_ready        : result valid/ready handshake
module neuron_feeder
    import adapter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   vec_len,
    output logic          busy,
    output logic          w_rd_en,
    output logic [AW-1:0] w_addr,
    input  fp_word_t      w_rdata,
    output logic          d_rd_en,
    output logic [AW-1:0] d_addr,
    input  fp_word_t      d_rdata,
    output fp_word_t      n_weight,
    output fp_word_t      n_data,
    output logic          n_en,
    output logic          n_clear,
    input  fp_word_t      n_accum,
    output fp_word_t      res_data,
    output logic          res_valid,
    input  logic          res_ready
);
    localparam logic [AW:0] LEN_W = (AW+1)'(LEN);

    feeder_state_t state, nxt;
    logic [AW-1:0] count;
    logic [AW:0]   len_q;
    logic          en_q;
    logic          last;

    assign last      = {1'b0, count} == len_q - 1'b1;
    assign busy      = state != IDLE;
    assign w_rd_en   = state == FETCH;
    assign d_rd_en   = state == FETCH;
    assign w_addr    = count;
    assign d_addr    = count;
    assign n_weight  = w_rdata;
    assign n_data    = d_rdata;
    assign n_clear   = state == CLEAR;
    assign n_en      = en_q;
    assign res_valid = state == HOLD;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = len_q == '0 ? CAPTURE : FETCH;
            FETCH:   nxt = last ? DRAIN : FETCH;
            DRAIN:   nxt = CAPTURE;
            CAPTURE: nxt = HOLD;
            HOLD:    nxt = res_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    // count holds at its last address after FETCH so the address never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            len_q    <= '0;
            en_q     <= 1'b0;
            res_data <= '0;
        end else begin
            state    <= nxt;
            count    <= state == IDLE ? '0 : (state == FETCH && !last) ? count + 1'b1 : count;
            len_q    <= (state == IDLE && start) ? (vec_len > LEN_W ? LEN_W : vec_len) : len_q;
            en_q     <= state == FETCH;
            res_data <= state == CAPTURE ? n_accum : res_data;
        end
    end
endmodule

// File: tb/tb_neuron_feeder.sv
// tb_neuron_feeder: directed self-checking bench with behavioural memories and an integer stub neuron
module tb_neuron_feeder;
    import adapter_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   vec_len = '0;
    logic          busy, w_rd_en, d_rd_en, n_en, n_clear, res_valid;
    logic [AW-1:0] w_addr, d_addr;
    fp_word_t      w_rdata = '0, d_rdata = '0, n_weight, n_data, n_accum, res_data;
    logic          res_ready = 1'b0;
    fp_word_t      w_mem [LEN];
    fp_word_t      d_mem [LEN];
    int            acc = 0;
    int            checks = 0;
    int            errors = 0;

    neuron_feeder dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .d_rd_en(d_rd_en), .d_addr(d_addr), .d_rdata(d_rdata),
        .n_weight(n_weight), .n_data(n_data), .n_en(n_en), .n_clear(n_clear),
        .n_accum(n_accum), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= w_mem[w_addr];
        if (d_rd_en) d_rdata <= d_mem[d_addr];
        if (n_clear) acc <= 0;
        else if (n_en) acc <= acc + int'(n_weight) * int'(n_data);
    end
    assign n_accum = fp_word_t'(acc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // leaves the bench in cycle 1, start having been sampled at edge 0
    task automatic go(input int len);
        vec_len = (AW+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input int w_base, input int w_step, input int d_base, input int d_step);
        for (int k = 0; k < LEN; k++) begin
            w_mem[k] = fp_word_t'(w_base + w_step * k);
            d_mem[k] = fp_word_t'(d_base + d_step * k);
        end
    endtask

    initial begin
        int reads, max_addr, cyc;
        #2;
        check("rst_busy", busy, 0);
        check("rst_rd_en", w_rd_en | d_rd_en, 0);
        check("rst_n_en", n_en, 0);
        check("rst_n_clear", n_clear, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_addr", w_addr | d_addr, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b1;
        tick();
        tick();

        // basic run: weights 1, data k+1, length 4 -> 10
        fill(1, 0, 1, 1);
        res_ready = 1'b1;
        go(4);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("basic_n_clear_c%0d", c), n_clear, c == 1);
            check($sformatf("basic_n_en_c%0d", c), n_en, c >= 3 && c <= 6);
            check($sformatf("basic_rd_en_c%0d", c), w_rd_en, c >= 2 && c <= 5);
            check($sformatf("basic_valid_c%0d", c), res_valid, c == 8);
            if (c >= 2 && c <= 5) check($sformatf("basic_addr_c%0d", c), w_addr, c - 2);
            if (c == 8) check("basic_res_data", res_data, 10);
            tick();
        end
        check("basic_idle", busy, 0);

        // backpressure: 3 x (2*3) = 18 held while res_ready is low
        fill(2, 0, 3, 0);
        res_ready = 1'b0;
        go(3);
        for (int c = 1; c < 7; c++) tick();
        for (int c = 7; c <= 11; c++) begin
            check($sformatf("bp_valid_c%0d", c), res_valid, 1);
            check($sformatf("bp_data_c%0d", c), res_data, 18);
            check($sformatf("bp_busy_c%0d", c), busy, 1);
            start = c == 8;
            vec_len = 1;
            if (c == 11) begin
                res_ready = 1'b1;
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check("bp_exit_busy", busy, 0);
        check("bp_exit_valid", res_valid, 0);
        tick();
        check("bp_no_queue", busy, 0);

        // zero length: straight to CAPTURE, result 0 in cycle 3
        go(0);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("zero_n_en_c%0d", c), n_en, 0);
            check($sformatf("zero_valid_c%0d", c), res_valid, c == 3);
            if (c == 3) check("zero_res_data", res_data, 0);
            tick();
        end

        // oversize length clamps to LEN reads, addresses 0..LEN-1
        fill(1, 0, 1, 0);
        reads = 0;
        max_addr = 0;
        cyc = 1;
        go(LEN + 5);
        while (!res_valid && cyc < 200) begin
            if (w_rd_en) begin
                reads++;
                if (int'(w_addr) > max_addr) max_addr = int'(w_addr);
            end
            tick();
            cyc++;
        end
        check("clamp_reads", reads, LEN);
        check("clamp_max_addr", max_addr, LEN - 1);
        check("clamp_latency", cyc, LEN + 4);
        check("clamp_res_data", res_data, LEN);
        tick();

        // async reset mid-run
        go(10);
        for (int c = 1; c < 5; c++) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd_en", w_rd_en | d_rd_en, 0);
        check("arst_n_en", n_en, 0);
        check("arst_n_clear", n_clear, 0);
        check("arst_valid", res_valid, 0);
        check("arst_addr", w_addr | d_addr, 0);
        check("arst_res_data", res_data, 0);
        rst = 1'b1;
        tick();
        w_mem[0] = 1; w_mem[1] = 1;
        d_mem[0] = 7; d_mem[1] = 8;
        go(2);
        for (int c = 1; c < 6; c++) tick();
        check("post_rst_valid", res_valid, 1);
        check("post_rst_res_data", res_data, 15);
        tick();

        // back-to-back: weights k+1, data 2; len 2 -> 6, then len 5 -> 30
        fill(1, 1, 2, 0);
        go(2);
        for (int c = 1; c <= 17; c++) begin
            if (c == 6) check("b2b_first_data", res_data, 6);
            if (c == 7) check("b2b_idle_gap", busy, 0);
            if (c >= 8 && c <= 9) check($sformatf("b2b_no_early_en_c%0d", c), n_en, 0);
            if (c == 8) check("b2b_second_clear", n_clear, 1);
            if (c == 10) check("b2b_second_en", n_en, 1);
            if (c == 16) check("b2b_second_valid", res_valid, 1);
            if (c == 16) check("b2b_second_data", res_data, 30);
            if (c == 17) check("b2b_done", busy, 0);
            check($sformatf("b2b_exclusive_c%0d", c), n_en & n_clear, 0);
            start = c == 7;
            vec_len = 5;
            tick();
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
Sequencer directly upstream of the neuron accumulator. On a start pulse it clears the neuron. It then streams vec_len weight/data pairs from two synchronous-read memories into the neuron, one pair per cycle, with n_en aligned to the returned read data. When accumulation is finished it captures n_accum and offers it downstream on a valid/ready handshake. It is data-agnostic: it moves and stores the 14-bit float words but does no arithmetic on them.

Parameters:
BITWIDTH, 12, base float width; a word is BITWIDTH+2 bits (two exception bits plus BITWIDTH).
BW, BITWIDTH+1, MSB index of a word.
LEN, 64, maximum vector length (also the memory depth).
AW, $clog2(LEN), memory address width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
start  in  1  one-cycle request; sampled only in IDLE.
vec_len  in  AW+1  number of pairs to accumulate; latched on accepted start; values above LEN clamp to LEN.
busy  out  1  high in every state except IDLE.
w_rd_en  out  1  weight memory read enable.
w_addr  out  AW  weight memory address.
w_rdata  in  BW+1  weight read data, valid one cycle after w_rd_en.
d_rd_en  out  1  data memory read enable.
d_addr  out  AW  data memory address.
d_rdata  in  BW+1  data read data, valid one cycle after d_rd_en.
n_weight  out  BW+1  to neuron weight; combinational pass-through of w_rdata.
n_data  out  BW+1  to neuron data; combinational pass-through of d_rdata.
n_en  out  1  to neuron en.
n_clear  out  1  to neuron clear.
n_accum  in  BW+1  from neuron accum.
res_data  out  BW+1  captured accumulation result.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst=0, async): state=IDLE. busy, w_rd_en, d_rd_en, n_en, n_clear and res_valid are 0. w_addr, d_addr and res_data are 0. The latched length is 0.
- FSM states are IDLE, CLEAR, FETCH, DRAIN, CAPTURE and HOLD.
- IDLE: start=1 latches the clamped vec_len into len_q and moves to CLEAR.
- CLEAR: n_clear=1 for exactly one cycle, with the address counter at 0.
  - If len_q=0, go to CAPTURE.
  - Otherwise go to FETCH.
- FETCH: w_rd_en=d_rd_en=1 and w_addr=d_addr=count, incrementing by 1 each cycle.
  - On the cycle count=len_q-1, go to DRAIN.
  - count never wraps, because len_q≤LEN.
- n_en is the read enable delayed by one register (high for the cycle after each read). Each n_en cycle therefore lines up with valid rdata.
- DRAIN: no read is issued; the final n_en is high. Go to CAPTURE.
- CAPTURE: n_accum now holds the final sum. Register res_data<=n_accum and res_valid<=1, then go to HOLD.
- HOLD: res_valid=1 and res_data is held stable.
  - On res_valid&res_ready, clear res_valid and return to IDLE.
  - start is ignored while in HOLD, including on the same cycle as the handshake.
- Timing with start sampled at edge 0:
  - n_clear is high in cycle 1.
  - Reads are issued in cycles 2..N+1.
  - n_en is high in cycles 3..N+2.
  - res_valid rises in cycle N+4 (latency N+4 cycles; with len_q=0, CLEAR goes straight to CAPTURE and res_valid rises in cycle 3).
- n_en and n_clear are never high in the same cycle.
- n_en is low in IDLE, CLEAR and HOLD.
- start in any non-IDLE state is dropped; no queueing.
- Reset asserted mid-run: asynchronous return to IDLE with all outputs at their reset values. Any partial neuron accumulation is discarded by the n_clear of the next run.
- The back-to-back throughput limit is one vector per N+5 cycles when res_ready is tied high.

Decomposition:
- Shared package adapter_pkg holds:
  - the word type logic [BW:0] (fp_word_t);
  - the feeder state enum (IDLE, CLEAR, FETCH, DRAIN, CAPTURE, HOLD);
  - the LEN and BITWIDTH defaults.
- No sub-module. The FSM, counter, one-stage n_en pipe and result register live in neuron_feeder.
- The parent stage instantiates neuron_feeder alongside neuron.

Test Plan:
- Bench setup: memories are behavioural 1-cycle-latency models. n_accum comes from an integer stub neuron (clear→0; en→accum+=weight*data) so sums are exact.
- Basic run: weights all 1, data[k]=k+1, vec_len=4, start at cycle 0 → n_clear in cycle 1; n_en in cycles 3–6; res_valid in cycle 8 with res_data=10; result consumed with res_ready=1.
- Backpressure: vec_len=3, weights 2, data 3, res_ready=0 for 5 cycles → res_valid=1 and res_data=18 held stable throughout; busy=1; a start during HOLD is ignored; IDLE only after res_ready=1.
- Boundaries: vec_len=0 → n_en never high, res_data=0, latency 3. vec_len=LEN+5 → exactly LEN reads, w_addr tops out at LEN-1 with no wrap.
- Async reset at cycle 5 of a vec_len=10 run → all outputs 0 immediately. A following start with vec_len=2 (weights 1, data 7,8) → res_data=15.
- Back-to-back runs with res_ready tied 1: vec_len=2 then 5 → second n_clear precedes any second-run n_en; both sums correct; an idle start is accepted on the cycle after HOLD exits.
